// File: rtl/spi_txn_master.sv
// SPI transaction master: serialises one 16-bit {addr, rw, data} frame per request
// and returns read data with a single-cycle response strobe.
module spi_txn_master #(
    parameter int HALF_PERIOD = 25,
    parameter int GAP         = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic       abort,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       aborted,
    output logic       busy,
    output logic       sclk_pin,
    output logic       cs_pin,
    output logic       mosi_pin,
    input  logic       miso_pin
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam int CNT_MAX = (HALF_PERIOD > GAP) ? HALF_PERIOD : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       idx_reg, idx_next;
    logic [15:0]      frame_reg, frame_next;
    logic [7:0]       cap_reg, cap_next;
    logic [7:0]       rdata_reg, rdata_next;
    logic             cs_reg, cs_next;
    logic             sclk_reg, sclk_next;
    logic             mosi_reg, mosi_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic             aborted_reg, aborted_next;
    logic [3:0]       idx_dec;
    logic             half_done;
    logic             is_read;

    assign idx_dec   = idx_reg - 4'd1;
    assign half_done = (cnt_reg == HALF_LAST);
    assign is_read   = frame_reg[8];

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg + CNT_W'(1);
        idx_next       = idx_reg;
        frame_next     = frame_reg;
        cap_next       = cap_reg;
        rdata_next     = rdata_reg;
        cs_next        = cs_reg;
        sclk_next      = sclk_reg;
        mosi_next      = mosi_reg;
        rsp_valid_next = 1'b0;
        aborted_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (req_valid) begin
                    state_next = ST_SHIFT_LO;
                    // The data field of a read frame goes out as zeros.
                    frame_next = {req_addr, req_rw, req_rw ? 8'h00 : req_wdata};
                    idx_next   = 4'd15;
                    cap_next   = 8'h00;
                    cs_next    = 1'b0;
                    sclk_next  = 1'b0;
                    mosi_next  = req_addr[6];
                end
            end
            ST_SHIFT_LO: begin
                if (half_done) begin
                    state_next = ST_SHIFT_HI;
                    cnt_next   = '0;
                    sclk_next  = 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                if (half_done) begin
                    cnt_next  = '0;
                    sclk_next = 1'b0;
                    // Sample as late as possible in the high half; data bits are idx 7..0.
                    if (is_read && !idx_reg[3]) begin
                        cap_next = {cap_reg[6:0], miso_pin};
                    end
                    if (idx_reg == 4'd0) begin
                        state_next = ST_HOLD;
                        mosi_next  = 1'b0;
                    end else begin
                        state_next = ST_SHIFT_LO;
                        idx_next   = idx_dec;
                        mosi_next  = frame_reg[idx_dec];
                    end
                end
            end
            ST_HOLD: begin
                if (half_done) begin
                    state_next     = ST_GAP;
                    cnt_next       = '0;
                    cs_next        = 1'b1;
                    rsp_valid_next = 1'b1;
                    if (is_read) begin
                        rdata_next = cap_reg;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        // Abort overrides any in-frame transition, including a normal completion.
        if (abort && (state_reg == ST_SHIFT_LO || state_reg == ST_SHIFT_HI ||
                      state_reg == ST_HOLD)) begin
            state_next     = ST_GAP;
            cnt_next       = '0;
            cap_next       = cap_reg;
            rdata_next     = rdata_reg;
            cs_next        = 1'b1;
            sclk_next      = 1'b0;
            mosi_next      = 1'b0;
            rsp_valid_next = 1'b0;
            aborted_next   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            idx_reg       <= 4'd0;
            frame_reg     <= 16'h0000;
            cap_reg       <= 8'h00;
            rdata_reg     <= 8'h00;
            cs_reg        <= 1'b1;
            sclk_reg      <= 1'b0;
            mosi_reg      <= 1'b0;
            rsp_valid_reg <= 1'b0;
            aborted_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            frame_reg     <= frame_next;
            cap_reg       <= cap_next;
            rdata_reg     <= rdata_next;
            cs_reg        <= cs_next;
            sclk_reg      <= sclk_next;
            mosi_reg      <= mosi_next;
            rsp_valid_reg <= rsp_valid_next;
            aborted_reg   <= aborted_next;
        end
    end

    assign req_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rdata_reg;
    assign aborted   = aborted_reg;
    assign sclk_pin  = sclk_reg;
    assign cs_pin    = cs_reg;
    assign mosi_pin  = mosi_reg;

endmodule

// File: tb/tb_spi_txn_master.sv
// Bench for spi_txn_master: a behavioural SPI memory slave on the pins, plus a
// transaction-level memory/response model predicting every frame's outcome.
module tb_spi_txn_master;

    localparam int H = 25;
    localparam int G = 250;
    localparam int RSP_CYC   = 33 * H + 1;
    localparam int READY_CYC = 33 * H + 1 + G;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       abort;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       aborted;
    logic       busy;
    logic       sclk_pin;
    logic       cs_pin;
    logic       mosi_pin;
    logic       miso_pin = 1'b0;

    spi_txn_master #(.HALF_PERIOD(H), .GAP(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .abort     (abort),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .aborted   (aborted),
        .busy      (busy),
        .sclk_pin  (sclk_pin),
        .cs_pin    (cs_pin),
        .mosi_pin  (mosi_pin),
        .miso_pin  (miso_pin)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI memory slave: samples mosi on sclk rise, drives miso after sclk fall.
    logic [7:0]  slave_mem [128] = '{default: 8'h00};
    logic        sclk_q = 1'b0;
    logic        cs_q = 1'b1;
    int          s_cnt = 0;
    logic [15:0] s_shift = 16'h0000;
    logic [6:0]  s_addr = 7'h00;
    logic        s_rw = 1'b0;
    logic [15:0] last_frame = 16'h0000;
    int          last_cnt = 0;

    always @(posedge clk) begin
        sclk_q <= sclk_pin;
        cs_q   <= cs_pin;
        if (cs_pin && !cs_q) begin
            last_frame <= s_shift;
            last_cnt   <= s_cnt;
            if (s_cnt == 16 && !s_shift[8]) slave_mem[s_shift[15:9]] <= s_shift[7:0];
            s_cnt <= 0;
        end else if (cs_pin) begin
            s_cnt <= 0;
        end else if (sclk_pin && !sclk_q) begin
            s_shift <= {s_shift[14:0], mosi_pin};
            s_cnt   <= s_cnt + 1;
            if (s_cnt == 7) begin
                s_addr <= s_shift[6:0];
                s_rw   <= mosi_pin;
            end
        end else if (!sclk_pin && sclk_q && s_cnt >= 8 && s_cnt < 16 && s_rw) begin
            miso_pin <= slave_mem[s_addr][3'(15 - s_cnt)];
        end
    end

    int checks = 0;
    int errors = 0;
    int base = 0;
    int acc_cyc = 0;
    int txn_no = 0;
    logic [7:0] ref_mem [128];
    logic [7:0] ref_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 of the accepted frame.
    task automatic start(input logic rw, input logic [6:0] a, input logic [7:0] wd);
        int n;
        n = 0;
        while (!req_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_req", 32'(req_ready), 32'd1);
        req_rw    = rw;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        base    = cyc - 1;
    endtask

    task automatic run_frame(input logic rw, input logic [6:0] a, input logic [7:0] wd,
                             input int abort_at, input logic chain,
                             input logic nrw, input logic [6:0] na, input logic [7:0] nwd);
        int c, rises, rsp_cnt, ab_cnt, rsp_c, ready_c, cs_high, ab_c;
        logic [7:0] rsp_rd, exp_rd;
        logic sclk_prev, ab_done;
        start(rw, a, wd);
        check("busy_c1", 32'(busy), 32'd1);
        check("cs_c1", 32'(cs_pin), 32'd0);
        check("mosi_c1", 32'(mosi_pin), 32'(a[6]));
        if (chain) begin
            req_rw = nrw; req_addr = na; req_wdata = nwd;
        end else begin
            req_valid = 1'b0;
        end
        rises = 0; rsp_cnt = 0; ab_cnt = 0; rsp_c = -1; ready_c = -1; cs_high = 0; ab_c = -1;
        rsp_rd = 8'h00; sclk_prev = 1'b0; ab_done = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            c = cyc - base;
            if (ab_done && c == ab_c + 1) begin
                abort = 1'b0;
                check("abort_cs", 32'(cs_pin), 32'd1);
                check("abort_sclk", 32'(sclk_pin), 32'd0);
                check("abort_mosi", 32'(mosi_pin), 32'd0);
                check("abort_pulse", 32'(aborted), 32'd1);
            end
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_c  = c;
                rsp_rd = rsp_rdata;
            end
            if (aborted) ab_cnt++;
            if (cs_pin) cs_high++;
            if (sclk_pin && !sclk_prev) rises++;
            sclk_prev = sclk_pin;
            if (abort_at != 0 && !ab_done && rises == abort_at) begin
                abort   = 1'b1;
                ab_done = 1'b1;
                ab_c    = c;
            end
            if (req_ready) begin
                ready_c = c;
                break;
            end
            @(negedge clk);
        end
        if (abort_at == 0) begin
            exp_rd = rw ? ref_mem[a] : ref_rdata;
            check("rsp_count", 32'(rsp_cnt), 32'd1);
            check("rsp_cycle", 32'(rsp_c), 32'(RSP_CYC));
            check("rsp_rdata", 32'(rsp_rd), 32'(exp_rd));
            check("ready_cycle", 32'(ready_c), 32'(READY_CYC));
            check("aborted_none", 32'(ab_cnt), 32'd0);
            check("mosi_frame", 32'(last_frame), 32'({a, rw, rw ? 8'h00 : wd}));
            check("sclk_rises", 32'(last_cnt), 32'd16);
            check("cs_gap", 32'(cs_high >= G), 32'd1);
            if (rw) ref_rdata = ref_mem[a];
            else ref_mem[a] = wd;
        end else begin
            check("abort_rsp_count", 32'(rsp_cnt), 32'd0);
            check("abort_count", 32'(ab_cnt), 32'd1);
            check("abort_rdata_held", 32'(rsp_rdata), 32'(ref_rdata));
            check("abort_ready_cycle", 32'(ready_c), 32'(ab_c + 1 + G));
            check("abort_rises", 32'(last_cnt), 32'(abort_at));
        end
        check("slave_mem", 32'(slave_mem[a]), 32'(ref_mem[a]));
        $display("txn %0d: rw=%0d addr=%02h wdata=%02h abort_at=%0d rsp_cycle=%0d rdata=%02h ready_cycle=%0d",
                 txn_no, rw, a, wd, abort_at, rsp_c, rsp_rd, ready_c);
        txn_no++;
    endtask

    initial begin
        int acc1, rsp_seen, ab;
        logic rw;
        logic [6:0] a;
        logic [7:0] wd;

        for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
        ref_rdata = 8'h00;
        rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = 7'h00;
        req_wdata = 8'h00; abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs", 32'(cs_pin), 32'd1);
        check("rst_sclk", 32'(sclk_pin), 32'd0);
        check("rst_mosi", 32'(mosi_pin), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(1'b0, 7'h04, 8'hF0, 0, 1'b0, 1'b0, 7'h00, 8'h00);
        check("write_frame_bits", 32'(last_frame), 32'h08F0);
        run_frame(1'b1, 7'h04, 8'h00, 0, 1'b0, 1'b0, 7'h00, 8'h00);
        run_frame(1'b0, 7'h04, 8'h00, 12, 1'b0, 1'b0, 7'h00, 8'h00);
        run_frame(1'b1, 7'h04, 8'h00, 0, 1'b0, 1'b0, 7'h00, 8'h00);

        run_frame(1'b0, 7'h0C, 8'h0F, 0, 1'b1, 1'b1, 7'h0C, 8'h00);
        acc1 = acc_cyc;
        run_frame(1'b1, 7'h0C, 8'h00, 0, 1'b0, 1'b0, 7'h00, 8'h00);
        check("b2b_accept_cycle", 32'(acc_cyc - acc1), 32'(READY_CYC));

        run_frame(1'b1, 7'h7F, 8'h00, 0, 1'b0, 1'b0, 7'h00, 8'h00);
        run_frame(1'b1, 7'h04, 8'h00, 0, 1'b0, 1'b0, 7'h00, 8'h00);
        run_frame(1'b0, 7'h10, 8'h55, 0, 1'b0, 1'b0, 7'h00, 8'h00);

        // Reset in the middle of a read.
        start(1'b1, 7'h0C, 8'h00);
        req_valid = 1'b0;
        rsp_seen = 0;
        for (int k = 0; k < 500 && (cyc - base) < 400; k++) begin
            if (rsp_valid) rsp_seen++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_cs", 32'(cs_pin), 32'd1);
        check("mrst_sclk", 32'(sclk_pin), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_ready", 32'(req_ready), 32'd1);
        check("mrst_rdata", 32'(rsp_rdata), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_ready_release", 32'(req_ready), 32'd1);
        for (int k = 0; k < 900; k++) begin
            if (rsp_valid) rsp_seen++;
            @(negedge clk);
        end
        check("mrst_no_rsp", 32'(rsp_seen), 32'd0);
        ref_rdata = 8'h00;
        $display("txn %0d: reset during read of 0c at cycle 400", txn_no);
        txn_no++;

        for (int t = 0; t < 12; t++) begin
            rw = 1'($urandom_range(0, 1));
            a  = 7'($urandom_range(0, 127));
            wd = 8'($urandom_range(0, 255));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0;
            run_frame(rw, a, wd, ab, 1'b0, 1'b0, 7'h00, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_txn_master.md
# spi_txn_master

Host-side SPI transaction engine that drives the `spiMemory` slave's `sclk_pin`/`cs_pin`/`mosi_pin` and captures `miso_pin`. It accepts one read or write request at a time on a valid/ready interface, serialises a 16-bit frame (7-bit address, R/W bit, 8-bit data, all MSB first) and returns read data with a one-cycle response strobe. It sits directly upstream of the SPI memory, on the same 50 MHz `clk`.

## Interface
Parameters:
- HALF_PERIOD, 25: `clk` cycles per sclk half-period (25 gives 1 MHz at 50 MHz); legal minimum 4.
- GAP, 250: minimum `clk` cycles `cs_pin` stays high between frames.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on a cycle with req_valid && req_ready.
- req_rw  in  1  1 = read, 0 = write.
- req_addr  in  7  memory address.
- req_wdata  in  8  write data; ignored for reads.
- abort  in  1  terminate the current frame.
- rsp_valid  out  1  one-cycle pulse at normal frame completion, for both reads and writes.
- rsp_rdata  out  8  read data; updated only on completed reads, held otherwise.
- aborted  out  1  one-cycle pulse when a frame is aborted.
- busy  out  1  high from the cycle after accept until the return to IDLE.
- sclk_pin  out  1  SPI clock; idles low.
- cs_pin  out  1  chip select, active-low.
- mosi_pin  out  1  serial data to the slave.
- miso_pin  in  1  serial data from the slave.

## Operation
- Frame register at accept: {req_addr, req_rw, req_wdata}. The read data field is sent as 0.
- Inputs are ignored after accept.
- States and transitions:
  - IDLE → SHIFT_LO on accept.
  - SHIFT_LO → SHIFT_HI after HALF_PERIOD cycles.
  - SHIFT_HI → SHIFT_LO after HALF_PERIOD cycles; after the 16th HI half it goes to HOLD instead.
  - HOLD → GAP after HALF_PERIOD cycles.
  - GAP → IDLE after GAP cycles.
- Bit index runs 15 down to 0.
- SHIFT_LO: `sclk_pin`=0; `mosi_pin` = frame[idx], changed only on the first LO cycle.
- SHIFT_HI: `sclk_pin`=1. On the last HI cycle of idx 7..0, if reading, `miso_pin` is shifted into the capture register (MSB first).
- HOLD: `cs_pin`=0, `sclk_pin`=0, `mosi_pin`=0.
- Entering GAP normally: `cs_pin`=1, rsp_valid=1 for that single cycle, rsp_rdata loaded with the captured byte if reading.
- abort while in SHIFT_LO, SHIFT_HI or HOLD:
  - Next cycle: `cs_pin`=1, `sclk_pin`=0, `mosi_pin`=0, aborted=1 for one cycle, state → GAP.
  - No rsp_valid; rsp_rdata unchanged.
- abort in IDLE or GAP is ignored. abort together with an accept in IDLE: the request is accepted and the abort is ignored.
- Reset values: `cs_pin`=1, `sclk_pin`=0, `mosi_pin`=0, req_ready=1 (IDLE), busy=0, rsp_valid=0, aborted=0, rsp_rdata=0x00.
- Reset mid-frame takes effect on the next edge with the same values. No response is issued, and the GAP is skipped.

## Timing
- Accept at cycle 0. Let H = HALF_PERIOD.
- Bit idx occupies:
  - LO cycles 1+2H(15−idx) .. H+2H(15−idx).
  - HI cycles H+1+2H(15−idx) .. 2H(16−idx).
- HOLD: cycles 32H+1..33H.
- Cycle 33H+1: `cs_pin` high, rsp_valid. Defaults: cycle 826.
- req_ready returns at cycle 33H+1+GAP. Defaults: cycle 1076.
- Back-to-back: the earliest next accept is that cycle, so `cs_pin` is high for at least GAP cycles.
- `mosi_pin` is stable for all of each HI half. The slave samples on rising `sclk`.
- `cs_pin` is low for H cycles before the first rising edge and for H cycles after the last falling edge.

## Test plan
- Write addr 0x04, data 0xF0 against the spiMemory model → `mosi_pin` at the 16 rising edges = 0000100_0_11110000; rsp_valid at cycle 826; slave memory[0x04]=0xF0.
- Read addr 0x04 → R/W bit 1, `mosi_pin`=0 during the data phase; rsp_valid at cycle 826 with rsp_rdata=0xF0.
- Write 0x00 to 0x04, abort asserted after the 12th rising edge → next cycle `cs_pin`=1, `sclk_pin`=0, aborted pulse, no rsp_valid; a following read of 0x04 returns 0xF0.
- req_valid held high with two queued requests (write 0x0C=0x0F, then read 0x0C) → second accept at cycle 1076; `cs_pin` high for ≥250 cycles between frames; read returns 0x0F.
- rst_n low at cycle 400 of a read → next edge `cs_pin`=1, `sclk_pin`=0, busy=0, rsp_valid never pulses; req_ready=1 on release.
- Read of never-written addr 0x7F → rsp_rdata=0x00. Write response → rsp_valid pulses and rsp_rdata keeps its previous value.
